snack_consumer: RTL and testbench
=================================

Name: snack_consumer

Overview:
- Consumer end of the snack-placement interface: watches the pig's bounding box against the current snack box once per frame.
- On a hit it pulses `new_round` so the locator respawns the snack, and it advances `pig_growth` and `score`.
- It is the source of the `new_round` and `pig_growth` signals that the locator consumes.
- Sits between the pig-movement logic and the snack locator, clocked on the game clock.

Parameters:
- PIG_SIZE, 40, base pig edge length in pixels.
- GROWTH_STEP, 4, pixels added to `pig_growth` per snack eaten.
- MAX_GROWTH, 80, saturation ceiling for `pig_growth`.
- SCORE_W, 8, width of the `score` counter.
- COOLDOWN_FRAMES, 2, frame ticks to ignore overlaps after each respawn.
- TIMEOUT_FRAMES, 600, frames without a hit before a forced respawn (only used with SNACK_TIMEOUT_EN).

Ports:
- clk  in  1  game clock.
- rst  in  1  synchronous reset, active-low: `rst`==0 at a posedge resets the block.
- start  in  1  new-game request.
- game_active  in  1  high while play is running.
- frame_tick  in  1  one-cycle pulse per video frame.
- pigX, pigY  in  11  pig top-left corner.
- posX, posY  in  11  snack top-left corner.
- posX_end, posY_end  in  11  snack bottom-right corner.
- new_round  out  1  one-cycle respawn request to the locator.
- eaten  out  1  one-cycle pulse on a genuine hit.
- pig_growth  out  11  accumulated pig growth in pixels.
- score  out  SCORE_W  snacks eaten this game.
- cooling  out  1  high while in COOLDOWN.

Behaviour:
- Reset (`rst`==0 at posedge):
  - state=IDLE; `new_round`=0, `eaten`=0, `pig_growth`=0, `score`=0, `cooling`=0.
  - Cooldown counter and timeout counter are cleared.
- Overlap test (combinational, 12-bit arithmetic, no wrap):
  - pig_endX = pigX + PIG_SIZE + pig_growth; pig_endY likewise.
  - hit = (pigX <= posX_end) && (posX <= pig_endX) && (pigY <= posY_end) && (posY <= pig_endY).
  - Bounds are inclusive, so edge contact counts as a hit.
- States: IDLE, ARMED, EAT, COOLDOWN. All outputs are registered.
- IDLE:
  - `start`=1 && `game_active`=1: clear `pig_growth` and `score`, go to ARMED.
  - Otherwise stay in IDLE.
- ARMED:
  - At a posedge with `frame_tick`=1 and hit=1: state←EAT; `new_round`←1, `eaten`←1.
  - Same edge: `score`←`score`+1, saturating at all-ones.
  - Same edge: `pig_growth`←min(`pig_growth`+GROWTH_STEP, MAX_GROWTH).
  - Latency: outputs are high in the cycle immediately after the sampling edge.
  - Overlaps while `frame_tick`=0 are ignored.
- EAT:
  - Lasts exactly one cycle.
  - Next edge: `new_round`←0, `eaten`←0, cooldown counter←COOLDOWN_FRAMES, state←COOLDOWN.
- COOLDOWN:
  - `cooling`=1; hits are ignored.
  - Each `frame_tick` decrements the counter.
  - The edge that decrements the counter from 1 to 0 returns the block to ARMED.
  - COOLDOWN_FRAMES=0 is treated as 1.
- `game_active`=0 at any edge:
  - Next state is IDLE; `new_round`, `eaten` and `cooling` are forced to 0.
  - `pig_growth` and `score` hold their values, so the final score stays visible.
- `start`=1 while ARMED or COOLDOWN:
  - Clear `pig_growth`, `score` and both counters; go to ARMED.
  - No `new_round` pulse is issued.
- `start` takes priority over a hit on the same edge.
- Reset dominates every other input; reset in the middle of EAT drops the pulse.
- `new_round` never stays high for more than one consecutive cycle.
- At most one `new_round` per COOLDOWN_FRAMES+1 frames.

Optional Feature:
- Macro: SNACK_TIMEOUT_EN.
- Defined:
  - In ARMED, a frame counter increments on each `frame_tick` without a hit.
  - When it reaches TIMEOUT_FRAMES: pulse `new_round` for one cycle with `eaten`=0; `score` and `pig_growth` are unchanged; go to COOLDOWN.
  - The counter clears on any hit, on timeout, on `start` and in IDLE.
  - A hit on the timeout frame wins: it is treated as a normal EAT.
- Undefined:
  - The counter logic is absent and the snack never respawns without a hit.
  - TIMEOUT_FRAMES is ignored.

Test Plan:
- Reset then start: hold `rst`=0 for 2 cycles, release, pulse `start` with `game_active`=1 → state ARMED, `score`=0, `pig_growth`=0, `new_round`=0.
- Simple hit: pig (100,100), snack (120,120)-(130,130), `frame_tick` pulse → next cycle `new_round`=1 and `eaten`=1 for 1 cycle, `score`=1, `pig_growth`=4, `cooling`=1.
- Edge-touch hit: pig (100,100), PIG_SIZE 40, growth 0, snack at (140,100) → hit. The same with snack at (141,100) → no pulse.
- Cooldown: overlap held for 5 frames → exactly one `new_round` per 3 frames; `score` increments 1, then 2 after cooldown expires.
- Saturation: 25 hits → `pig_growth` stops at 80. With SCORE_W=4, after 15 hits `score` stays at 15 through the 16th hit.
- Mid-game stop/restart: drop `game_active` during COOLDOWN → IDLE, `score` held at 3. Then `start` → `score`=0. With SNACK_TIMEOUT_EN and TIMEOUT_FRAMES=4, no hit for 4 frames → one `new_round` with `eaten`=0 and `score` unchanged.

Source files
------------

// File: rtl/snack_consumer.sv
// snack_consumer: consumer end of the snack-placement interface.
// Once per frame it tests the pig bounding box against the snack box; a hit
// pulses new_round/eaten, bumps score (saturating) and pig_growth (capped at
// MAX_GROWTH), then ignores overlaps for COOLDOWN_FRAMES frames.
// Optional feature macro: SNACK_TIMEOUT_EN forces a respawn (new_round with
// eaten=0) after TIMEOUT_FRAMES frames in ARMED without a hit.
module snack_consumer #(
    parameter int PIG_SIZE        = 40,
    parameter int GROWTH_STEP     = 4,
    parameter int MAX_GROWTH      = 80,
    parameter int SCORE_W         = 8,
    parameter int COOLDOWN_FRAMES = 2,
    parameter int TIMEOUT_FRAMES  = 600
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               game_active,
    input  logic               frame_tick,
    input  logic [10:0]        pigX,
    input  logic [10:0]        pigY,
    input  logic [10:0]        posX,
    input  logic [10:0]        posY,
    input  logic [10:0]        posX_end,
    input  logic [10:0]        posY_end,
    output logic               new_round,
    output logic               eaten,
    output logic [10:0]        pig_growth,
    output logic [SCORE_W-1:0] score,
    output logic               cooling
);

    // A zero cooldown would let a held overlap fire on back-to-back frames.
    localparam int CD_EFF = (COOLDOWN_FRAMES < 1) ? 1 : COOLDOWN_FRAMES;
    localparam int CD_W   = $clog2(CD_EFF + 1);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_EAT, S_COOLDOWN} state_t;

    state_t              r_state, w_state_next;
    logic                r_new_round, w_new_round_next;
    logic                r_eaten, w_eaten_next;
    logic                r_cooling, w_cooling_next;
    logic [10:0]         r_growth, w_growth_next;
    logic [SCORE_W-1:0]  r_score, w_score_next;
    logic [CD_W-1:0]     r_cd_cnt, w_cd_next;

    // 12-bit overlap arithmetic so the pig's far edge never wraps.
    logic [11:0] w_pig_end_x, w_pig_end_y, w_growth_sum;
    logic        w_hit, w_frame_hit;

    assign w_pig_end_x  = {1'b0, pigX} + 12'(PIG_SIZE) + {1'b0, r_growth};
    assign w_pig_end_y  = {1'b0, pigY} + 12'(PIG_SIZE) + {1'b0, r_growth};
    assign w_hit        = (pigX <= posX_end) && ({1'b0, posX} <= w_pig_end_x) &&
                          (pigY <= posY_end) && ({1'b0, posY} <= w_pig_end_y);
    assign w_frame_hit  = frame_tick && w_hit;
    assign w_growth_sum = {1'b0, r_growth} + 12'(GROWTH_STEP);

`ifdef SNACK_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_FRAMES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_FRAMES - 1);

    logic [TO_W-1:0] r_to_cnt, w_to_next;
    logic            w_timeout;

    // Fires on the TIMEOUT_FRAMES-th consecutive hitless frame; a hit on that frame wins.
    assign w_timeout = frame_tick && !w_hit && (r_to_cnt == TO_LAST);
`endif

    // State and registered outputs; active-low synchronous reset dominates.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_new_round <= 1'b0;
            r_eaten     <= 1'b0;
            r_cooling   <= 1'b0;
            r_growth    <= '0;
            r_score     <= '0;
            r_cd_cnt    <= '0;
`ifdef SNACK_TIMEOUT_EN
            r_to_cnt    <= '0;
`endif
        end else begin
            r_state     <= w_state_next;
            r_new_round <= w_new_round_next;
            r_eaten     <= w_eaten_next;
            r_cooling   <= w_cooling_next;
            r_growth    <= w_growth_next;
            r_score     <= w_score_next;
            r_cd_cnt    <= w_cd_next;
`ifdef SNACK_TIMEOUT_EN
            r_to_cnt    <= w_to_next;
`endif
        end
    end

    // Next-state: game stop beats start, start beats a hit.
    always_comb begin
        w_state_next = r_state;
        if (!game_active) begin
            w_state_next = S_IDLE;
        end else if (start) begin
            w_state_next = S_ARMED;
        end else begin
            case (r_state)
                S_IDLE:     w_state_next = S_IDLE;
                S_ARMED: begin
                    if (w_frame_hit)
                        w_state_next = S_EAT;
`ifdef SNACK_TIMEOUT_EN
                    else if (w_timeout)
                        w_state_next = S_EAT;
`endif
                end
                S_EAT:      w_state_next = S_COOLDOWN;
                S_COOLDOWN: begin
                    if (frame_tick && (r_cd_cnt <= CD_W'(1)))
                        w_state_next = S_ARMED;
                end
                default:    w_state_next = S_IDLE;
            endcase
        end
    end

    // Next values of the registered outputs and counters.
    always_comb begin
        w_new_round_next = 1'b0;
        w_eaten_next     = 1'b0;
        w_cooling_next   = (w_state_next == S_COOLDOWN);
        w_growth_next    = r_growth;
        w_score_next     = r_score;
        w_cd_next        = r_cd_cnt;
`ifdef SNACK_TIMEOUT_EN
        w_to_next        = r_to_cnt;
`endif
        if (!game_active) begin
            // Score and growth hold so the final result stays visible.
            w_cd_next = '0;
`ifdef SNACK_TIMEOUT_EN
            w_to_next = '0;
`endif
        end else if (start) begin
            w_growth_next = '0;
            w_score_next  = '0;
            w_cd_next     = '0;
`ifdef SNACK_TIMEOUT_EN
            w_to_next     = '0;
`endif
        end else begin
            case (r_state)
                S_ARMED: begin
                    if (w_frame_hit) begin
                        w_new_round_next = 1'b1;
                        w_eaten_next     = 1'b1;
                        if (r_score != '1)
                            w_score_next = r_score + 1'b1;
                        if (w_growth_sum > 12'(MAX_GROWTH))
                            w_growth_next = 11'(MAX_GROWTH);
                        else
                            w_growth_next = w_growth_sum[10:0];
`ifdef SNACK_TIMEOUT_EN
                        w_to_next = '0;
                    end else if (w_timeout) begin
                        w_new_round_next = 1'b1;
                        w_to_next        = '0;
                    end else if (frame_tick) begin
                        w_to_next = r_to_cnt + 1'b1;
`endif
                    end
                end
                S_EAT: begin
                    w_cd_next = CD_W'(CD_EFF);
                end
                S_COOLDOWN: begin
                    if (frame_tick && (r_cd_cnt != '0))
                        w_cd_next = r_cd_cnt - 1'b1;
                end
                default: begin
`ifdef SNACK_TIMEOUT_EN
                    w_to_next = '0;
`endif
                end
            endcase
        end
    end

    assign new_round  = r_new_round;
    assign eaten      = r_eaten;
    assign cooling    = r_cooling;
    assign pig_growth = r_growth;
    assign score      = r_score;

endmodule

// File: tb/tb_snack_consumer.sv
// Testbench for snack_consumer: table of per-cycle vectors followed by
// hand-written sequences for saturation, timeout and reset-during-EAT.
module tb_snack_consumer;

    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          game_active = 1'b0;
    logic          frame_tick = 1'b0;
    logic [10:0]   pigX = 11'd100, pigY = 11'd100;
    logic [10:0]   posX = 11'd500, posY = 11'd500;
    logic [10:0]   posX_end = 11'd510, posY_end = 11'd510;
    logic          new_round, eaten, cooling;
    logic [10:0]   pig_growth;
    logic [SW-1:0] score;

    int n_cmp = 0;
    int n_bad = 0;

    snack_consumer #(
        .PIG_SIZE(40), .GROWTH_STEP(4), .MAX_GROWTH(80), .SCORE_W(SW),
        .COOLDOWN_FRAMES(2), .TIMEOUT_FRAMES(4)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .game_active(game_active),
        .frame_tick(frame_tick), .pigX(pigX), .pigY(pigY),
        .posX(posX), .posY(posY), .posX_end(posX_end), .posY_end(posY_end),
        .new_round(new_round), .eaten(eaten), .pig_growth(pig_growth),
        .score(score), .cooling(cooling)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       st, ga, ft;
        logic [10:0] sx, sy;
        logic       nr, ea, co;
        int         sc, gr;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_snack(input logic [10:0] x, input logic [10:0] y);
        posX = x; posY = y; posX_end = x + 11'd10; posY_end = y + 11'd10;
    endtask

    task automatic tick;
        @(posedge clk); #1;
    endtask

    // Ticks frames with the overlap held until a new_round is seen (bounded).
    task automatic do_hit(output bit got);
        got = 1'b0;
        frame_tick = 1'b1;
        for (int i = 0; i < 8 && !got; i++) begin
            tick();
            if (new_round === 1'b1) got = 1'b1;
        end
        frame_tick = 1'b0;
    endtask

    vec_t tbl[23];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        int exp_sc, exp_gr;

        // Pig at (100,100); snacks are 10x10; 500 means "far away".
        tbl[0]  = '{1,1,0,500,500, 0,0,0, 0, 0};
        tbl[1]  = '{0,1,1,141,100, 0,0,0, 0, 0};
        tbl[2]  = '{0,1,1,140,100, 1,1,0, 1, 4};
        tbl[3]  = '{0,1,0,120,120, 0,0,1, 1, 4};
        tbl[4]  = '{0,1,1,120,120, 0,0,1, 1, 4};
        tbl[5]  = '{0,1,0,120,120, 0,0,1, 1, 4};
        tbl[6]  = '{0,1,1,120,120, 0,0,0, 1, 4};
        tbl[7]  = '{0,1,0,120,120, 0,0,0, 1, 4};
        tbl[8]  = '{0,1,1,120,120, 1,1,0, 2, 8};
        tbl[9]  = '{0,1,0,120,120, 0,0,1, 2, 8};
        tbl[10] = '{0,1,1,120,120, 0,0,1, 2, 8};
        tbl[11] = '{0,1,1,120,120, 0,0,0, 2, 8};
        tbl[12] = '{0,1,1,120,120, 1,1,0, 3,12};
        tbl[13] = '{0,1,0,120,120, 0,0,1, 3,12};
        tbl[14] = '{0,0,1,120,120, 0,0,0, 3,12};
        tbl[15] = '{0,0,1,120,120, 0,0,0, 3,12};
        tbl[16] = '{0,1,1,120,120, 0,0,0, 3,12};
        tbl[17] = '{1,1,1,120,120, 0,0,0, 0, 0};
        tbl[18] = '{0,1,0,120,120, 0,0,0, 0, 0};
        tbl[19] = '{0,1,1,120,120, 1,1,0, 1, 4};
        tbl[20] = '{0,1,0,120,120, 0,0,1, 1, 4};
        tbl[21] = '{1,1,0,120,120, 0,0,0, 0, 0};
        tbl[22] = '{0,1,1,120,120, 1,1,0, 1, 4};

        // Reset held for two cycles.
        rst = 1'b0;
        tick(); tick();
        check("rst_new_round", new_round, 0);
        check("rst_eaten", eaten, 0);
        check("rst_cooling", cooling, 0);
        check("rst_score", score, 0);
        check("rst_growth", pig_growth, 0);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 23; i++) begin
            start = tbl[i].st; game_active = tbl[i].ga; frame_tick = tbl[i].ft;
            set_snack(tbl[i].sx, tbl[i].sy);
            tick();
            $display("vec %0d: nr=%0d ea=%0d co=%0d score=%0d growth=%0d",
                     i, new_round, eaten, cooling, score, pig_growth);
            check($sformatf("v%0d_new_round", i), new_round, tbl[i].nr);
            check($sformatf("v%0d_eaten", i), eaten, tbl[i].ea);
            check($sformatf("v%0d_cooling", i), cooling, tbl[i].co);
            check($sformatf("v%0d_score", i), score, tbl[i].sc);
            check($sformatf("v%0d_growth", i), pig_growth, tbl[i].gr);
        end
        start = 1'b0; frame_tick = 1'b0;

        // Saturation: hits 2..25 with the overlap held.
        for (int n = 2; n <= 25; n++) begin
            do_hit(got);
            check($sformatf("sat%0d_hit_seen", n), got, 1);
            check($sformatf("sat%0d_eaten", n), eaten, 1);
            exp_sc = (n < 15) ? n : 15;
            exp_gr = (4 * n < 80) ? 4 * n : 80;
            check($sformatf("sat%0d_score", n), score, exp_sc);
            check($sformatf("sat%0d_growth", n), pig_growth, exp_gr);
            $display("hit %0d: score=%0d growth=%0d", n, score, pig_growth);
            tick();
            check($sformatf("sat%0d_single_pulse", n), new_round, 0);
        end

        // Restart with the snack out of reach.
        set_snack(11'd500, 11'd500);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_score", score, 0);
        check("restart_growth", pig_growth, 0);
        check("restart_cooling", cooling, 0);

`ifdef SNACK_TIMEOUT_EN
        for (int k = 1; k <= 4; k++) begin
            frame_tick = 1'b1;
            tick();
            frame_tick = 1'b0;
            $display("timeout frame %0d: nr=%0d ea=%0d", k, new_round, eaten);
            check($sformatf("to%0d_new_round", k), new_round, (k == 4) ? 1 : 0);
            check($sformatf("to%0d_eaten", k), eaten, 0);
            if (k != 4) tick();
        end
        check("to_score", score, 0);
        check("to_growth", pig_growth, 0);
        tick();
        check("to_pulse_drop", new_round, 0);
        check("to_cooling", cooling, 1);
`else
        for (int k = 1; k <= 8; k++) begin
            frame_tick = 1'b1;
            tick();
            frame_tick = 1'b0;
            tick();
            $display("idle frame %0d: nr=%0d", k, new_round);
            check($sformatf("noto%0d_new_round", k), new_round, 0);
        end
        check("noto_cooling", cooling, 0);
`endif

        // Reset while in EAT clears everything.
        frame_tick = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        set_snack(11'd120, 11'd120);
        frame_tick = 1'b1;
        repeat (4) begin
            tick();
            if (new_round === 1'b1) break;
        end
        frame_tick = 1'b0;
        check("eat_rst_pre_pulse", new_round, 1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        $display("reset in EAT: nr=%0d score=%0d growth=%0d", new_round, score, pig_growth);
        check("eat_rst_new_round", new_round, 0);
        check("eat_rst_score", score, 0);
        check("eat_rst_growth", pig_growth, 0);
        check("eat_rst_cooling", cooling, 0);

        // After reset the block idles: overlap with no start gives no pulse.
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        check("post_rst_idle", new_round, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
